// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file
package regfile_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    function automatic int addr_bits(input int depth);
        return $clog2(depth);
    endfunction
    function automatic logic reg_ok(input logic [4:0] a, input int depth);
        return a != REG_ZERO && int'(a) < depth;
    endfunction
endpackage

// File: rtl/register_file_read_port.sv
// register_file_read_port: one read port with x0/range masking, write bypass and optional output register
module register_file_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGISTER_DEPTH = 32,
    parameter int REGISTERED_READ = 0,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [4:0]      ra,
    input  logic [XLEN-1:0] bank [REGISTER_DEPTH],
    input  logic            we0,
    input  logic [4:0]      wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [4:0]      wa1,
    input  logic [XLEN-1:0] wd1,
    output logic [XLEN-1:0] rd
);
    localparam int AW = addr_bits(REGISTER_DEPTH);
    logic            ok, hit0, hit1;
    logic [XLEN-1:0] nxt, rd_q;
    always_comb begin
        ok   = run && reg_ok(ra, REGISTER_DEPTH);
        hit1 = BYPASS != 0 && we1 && wa1 == ra;
        hit0 = BYPASS != 0 && we0 && wa0 == ra;
        nxt  = !ok ? '0 : hit1 ? wd1 : hit0 ? wd0 : bank[ra[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else     rd_q <= nxt;
    end
    assign rd = REGISTERED_READ != 0 ? rd_q : nxt;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with dual write, bypass and reset clear sequencer
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGISTER_DEPTH = 32,
    parameter int READ_PORTS = 2,
    parameter int REGISTERED_READ = 0,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic                       we0,
    input  logic [4:0]                 wa0,
    input  logic [XLEN-1:0]            wd0,
    input  logic                       we1,
    input  logic [4:0]                 wa1,
    input  logic [XLEN-1:0]            wd1,
    input  logic [5*READ_PORTS-1:0]    ra,
    output logic [XLEN*READ_PORTS-1:0] rd
);
    localparam int AW = addr_bits(REGISTER_DEPTH);
    state_t          state;
    logic [AW-1:0]   ptr;
    logic [XLEN-1:0] bank [1:REGISTER_DEPTH-1];
    logic [XLEN-1:0] bank_view [REGISTER_DEPTH];
    logic            run, w0_ok, w1_ok;
    always_comb begin
        run   = state == RUN;
        w0_ok = run && we0 && reg_ok(wa0, REGISTER_DEPTH);
        w1_ok = run && we1 && reg_ok(wa1, REGISTER_DEPTH);
    end
    // x0 is never stored; the read ports see a hard zero in its slot
    always_comb begin
        bank_view[0] = '0;
        for (int i = 1; i < REGISTER_DEPTH; i++) bank_view[i] = bank[i];
    end
    // port 1 is assigned last so it wins a same-address dual write
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= AW'(1);
            ready <= 1'b0;
        end else if (state == CLEAR) begin
            bank[ptr] <= '0;
            ptr       <= ptr + 1'b1;
            if (ptr == AW'(REGISTER_DEPTH - 1)) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else begin
            if (w0_ok) bank[wa0[AW-1:0]] <= wd0;
            if (w1_ok) bank[wa1[AW-1:0]] <= wd1;
        end
    end
    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rp
        register_file_read_port #(
            .XLEN(XLEN),
            .REGISTER_DEPTH(REGISTER_DEPTH),
            .REGISTERED_READ(REGISTERED_READ),
            .BYPASS(BYPASS)
        ) u_rp (
            .clk(clk),
            .rst(rst),
            .run(run),
            .ra(ra[5*g +: 5]),
            .bank(bank_view),
            .we0(w0_ok),
            .wa0(wa0),
            .wd0(wd0),
            .we1(w1_ok),
            .wa1(wa1),
            .wd1(wd1),
            .rd(rd[XLEN*g +: XLEN])
        );
    end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: scoreboard bench for a rv32i combinational/bypass bank and a rv32e registered/no-bypass bank
module tb_register_file_mp;
    logic         clk = 1'b0;
    logic         rst, we0, we1;
    logic [4:0]   wa0, wa1;
    logic [31:0]  wd0, wd1;
    logic [9:0]   ra_a;
    logic [19:0]  ra_b;
    logic [63:0]  rd_a;
    logic [127:0] rd_b;
    logic         ready_a, ready_b;
    int           checks = 0, errors = 0;
    int           na, nb;
    typedef struct {
        string       tag;
        int          port;
        logic [31:0] exp;
    } exp_t;
    exp_t sba[$], sbb[$];

    always #5 clk = ~clk;

    register_file_mp #(.XLEN(32), .REGISTER_DEPTH(32), .READ_PORTS(2), .REGISTERED_READ(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra_a), .rd(rd_a)
    );
    register_file_mp #(.XLEN(32), .REGISTER_DEPTH(16), .READ_PORTS(4), .REGISTERED_READ(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra_b), .rd(rd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input string tag, input int port, input logic [31:0] exp);
        sba.push_back('{tag, port, exp});
    endtask

    task automatic push_b(input string tag, input int port, input logic [31:0] exp);
        sbb.push_back('{tag, port, exp});
    endtask

    task automatic drain_a();
        exp_t e;
        while (sba.size() > 0) begin
            e = sba.pop_front();
            chk(e.tag, rd_a[e.port*32 +: 32], e.exp);
        end
    endtask

    task automatic drain_b();
        exp_t e;
        while (sbb.size() > 0) begin
            e = sbb.pop_front();
            chk(e.tag, rd_b[e.port*32 +: 32], e.exp);
        end
    endtask

    // entered at a negedge with rst already low; counts edges until each bank is ready
    task automatic clear_count(output int ca, output int cb, input bit wr);
        ca = 0;
        cb = 0;
        for (int c = 1; c <= 40 && ca == 0; c++) begin
            we0 = wr && c <= 10;
            wa0 = 5'd9;
            wd0 = 32'h0000_0abc;
            ra_a = {5'd9, 5'd7};
            if (c <= 3) begin
                push_a("clear_rd0_p0", 0, 32'h0);
                push_a("clear_rd0_p1", 1, 32'h0);
                #1 drain_a();
            end
            @(posedge clk);
            #1;
            if (cb == 0 && ready_b) cb = c;
            if (ready_a) ca = c;
            @(negedge clk);
        end
        we0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        ra_a = '0; ra_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a", 32'(ready_a), 32'h0);
        chk("rst_ready_b", 32'(ready_b), 32'h0);
        chk("rst_rd_b", rd_b[31:0], 32'h0);
        push_a("rst_rd_a", 0, 32'h0);
        drain_a();
        rst = 1'b0;
        clear_count(na, nb, 1'b0);
        chk("clear_len_a", 32'(na), 32'd31);
        chk("clear_len_b", 32'(nb), 32'd15);

        for (int r = 0; r < 32; r++) begin
            ra_a = {5'(31 - r), 5'(r)};
            ra_b = {4{5'(r)}};
            push_a("zero_a_p0", 0, 32'h0);
            push_a("zero_a_p1", 1, 32'h0);
            for (int p = 0; p < 4; p++) push_b("zero_b", p, 32'h0);
            #1 drain_a();
            @(posedge clk);
            #1 drain_b();
            @(negedge clk);
        end

        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h1111_1111;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h2222_2222;
        ra_a = {5'd0, 5'd5};
        ra_b = {4{5'd5}};
        push_a("prio_byp_p0", 0, 32'h2222_2222);
        push_a("prio_byp_x0", 1, 32'h0);
        for (int p = 0; p < 4; p++) push_b("prio_old_b", p, 32'h0);
        #1 drain_a();
        @(posedge clk);
        #1 drain_b();
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
        ra_a = {5'd5, 5'd5};
        push_a("prio_a_p0", 0, 32'h2222_2222);
        push_a("prio_a_p1", 1, 32'h2222_2222);
        push_b("prio_b", 0, 32'h2222_2222);
        #1 drain_a();
        @(posedge clk);
        #1 drain_b();
        @(negedge clk);

        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hDEAD_BEEF;
        ra_a = {5'd5, 5'd7};
        ra_b = {5'd0, 5'd0, 5'd5, 5'd7};
        push_a("byp_a", 0, 32'hDEAD_BEEF);
        push_a("byp_a_other", 1, 32'h2222_2222);
        push_b("nobyp_b", 0, 32'h0);
        push_b("nobyp_b_other", 1, 32'h2222_2222);
        #1 drain_a();
        @(posedge clk);
        #1 drain_b();
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hA0A0_A0A0;
        we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hB1B1_B1B1;
        ra_a = {5'd7, 5'd7};
        ra_b = {5'd0, 5'd0, 5'd0, 5'd7};
        push_a("x7_a_p0", 0, 32'hDEAD_BEEF);
        push_a("x7_a_p1", 1, 32'hDEAD_BEEF);
        push_b("x7_b", 0, 32'hDEAD_BEEF);
        #1 drain_a();
        @(posedge clk);
        #1 drain_b();
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
        ra_a = {5'd11, 5'd10};
        ra_b = {5'd0, 5'd0, 5'd11, 5'd10};
        push_a("dual_a_x10", 0, 32'hA0A0_A0A0);
        push_a("dual_a_x11", 1, 32'hB1B1_B1B1);
        push_b("dual_b_x10", 0, 32'hA0A0_A0A0);
        push_b("dual_b_x11", 1, 32'hB1B1_B1B1);
        #1 drain_a();
        @(posedge clk);
        #1 drain_b();
        @(negedge clk);

        we0 = 1'b1; wa0 = 5'd0;  wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 5'd20; wd1 = 32'hFFFF_FFFF;
        ra_a = {5'd20, 5'd0};
        ra_b = {5'd7, 5'd5, 5'd4, 5'd20};
        push_a("x0_byp_a", 0, 32'h0);
        push_a("x20_byp_a", 1, 32'hFFFF_FFFF);
        #1 drain_a();
        for (int k = 0; k < 2; k++) begin
            push_b("x20_b", 0, 32'h0);
            push_b("x4_alias_b", 1, 32'h0);
            push_b("x5_keep_b", 2, 32'h2222_2222);
            push_b("x7_keep_b", 3, 32'hDEAD_BEEF);
            @(posedge clk);
            #1 drain_b();
            @(negedge clk);
            we0 = 1'b0; we1 = 1'b0;
        end
        push_a("x0_a", 0, 32'h0);
        push_a("x20_a", 1, 32'hFFFF_FFFF);
        #1 drain_a();

        we0 = 1'b1; wa0 = 5'd1; wd0 = 32'd1;
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'd2;
        ra_b = '0;
        @(negedge clk);
        wa0 = 5'd3; wd0 = 32'd3; we1 = 1'b0;
        @(negedge clk);
        we0 = 1'b0;
        @(negedge clk);
        ra_b = {5'd3, 5'd2, 5'd1, 5'd0};
        ra_a = {5'd2, 5'd1};
        #1 chk("lat_hold_b", rd_b[127:96], 32'h0);
        push_a("load_a_x1", 0, 32'd1);
        push_a("load_a_x2", 1, 32'd2);
        drain_a();
        for (int p = 0; p < 4; p++) push_b("reg4_b", p, 32'(p));
        @(posedge clk);
        #1 drain_b();
        @(negedge clk);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("midclr_ready_a", 32'(ready_a), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_count(na, nb, 1'b1);
        chk("reclear_len_a", 32'(na), 32'd31);
        chk("reclear_len_b", 32'(nb), 32'd15);
        ra_a = {5'd5, 5'd9};
        ra_b = {5'd3, 5'd7, 5'd5, 5'd9};
        push_a("reclr_x9_a", 0, 32'h0);
        push_a("reclr_x5_a", 1, 32'h0);
        for (int p = 0; p < 4; p++) push_b("reclr_b", p, 32'h0);
        #1 drain_a();
        @(posedge clk);
        #1 drain_b();
        chk("sb_empty", 32'(sba.size() + sbb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
